// File: rtl/axis_1553_decoder.sv
// MIL-STD-1553 Manchester II receiver with an AXI-Stream word output.
// One output register; words completing while it is stalled are dropped and flagged.
module axis_1553_decoder #(
  parameter int clock_speed = 20000000
) (
  input  logic        aclk,
  input  logic        arst,
  input  logic [1:0]  diff,
  output logic [15:0] m_axis_tdata,
  output logic        m_axis_tvalid,
  output logic [7:0]  m_axis_tuser,
  input  logic        m_axis_tready
);

  localparam int N  = clock_speed / 1000000;
  localparam int CW = $clog2(2 * N) + 1;

  localparam logic [CW-1:0] SMIN = CW'(3 * N / 2 - N / 4);
  localparam logic [CW-1:0] SMAX = CW'(3 * N / 2 + N / 4);
  localparam logic [CW-1:0] SEND = CW'(3 * N / 2 - 1);
  localparam logic [CW-1:0] Q1   = CW'(N / 4);
  localparam logic [CW-1:0] Q3   = CW'(3 * N / 4);
  localparam logic [CW-1:0] NM1  = CW'(N - 1);

  typedef enum logic [1:0] {IDLE, SYNC1, SYNC2, BITS} state_t;

  state_t        state;
  logic [1:0]    s1, s2, sp;
  logic          pol;
  logic [CW-1:0] cnt;
  logic [4:0]    idx;
  logic          h1;
  logic [15:0]   shreg;
  logic          ovf;

  logic hi, lo, vld, lvl, done, perr;

  assign hi  = (s2 == 2'b10);
  assign lo  = (s2 == 2'b01);
  assign vld = hi | lo;
  assign lvl = hi;

  // parity bit: its first half (h1) is the decoded bit value
  assign done = (state == BITS) && (cnt == Q3) && (idx == 5'd16)
              && vld && (lvl != h1);
  assign perr = ~(^{shreg, h1});

  always_ff @(posedge aclk or posedge arst) begin
    if (arst) begin
      s1            <= 2'b00;
      s2            <= 2'b00;
      sp            <= 2'b00;
      state         <= IDLE;
      pol           <= 1'b0;
      cnt           <= '0;
      idx           <= '0;
      h1            <= 1'b0;
      shreg         <= '0;
      ovf           <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tuser  <= '0;
    end else begin
      s1 <= diff;
      s2 <= s1;
      sp <= s2;

      unique case (state)
        IDLE: begin
          if (vld && (s2 != sp)) begin
            pol   <= hi;
            cnt   <= CW'(1);
            state <= SYNC1;
          end
        end
        SYNC1: begin
          if (!vld) begin
            state <= IDLE;
          end else if (lvl == pol) begin
            if (cnt >= SMAX) state <= IDLE;
            else cnt <= cnt + 1'b1;
          end else if (cnt >= SMIN) begin
            state <= SYNC2;
            cnt   <= CW'(1);
          end else begin
            state <= IDLE;
          end
        end
        SYNC2: begin
          if ((cnt == Q3) && !(vld && (lvl != pol))) begin
            state <= IDLE;
          end else if (cnt == SEND) begin
            state <= BITS;
            cnt   <= '0;
            idx   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        BITS: begin
          if (cnt == Q1) begin
            if (!vld) state <= IDLE;
            else h1 <= lvl;
          end
          if (cnt == Q3) begin
            if (!vld || (lvl == h1)) state <= IDLE;
            else if (idx == 5'd16) state <= IDLE;
            else shreg <= {shreg[14:0], h1};
          end
          if (cnt == NM1) begin
            cnt <= '0;
            idx <= idx + 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
      endcase

      // the sticky flag moves into the loaded word's tuser[2]
      if (done) begin
        if (m_axis_tvalid && !m_axis_tready) begin
          ovf <= 1'b1;
        end else begin
          m_axis_tdata  <= shreg;
          m_axis_tuser  <= {5'b00000, ovf, perr, pol};
          m_axis_tvalid <= 1'b1;
          ovf           <= 1'b0;
        end
      end else if (m_axis_tvalid && m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_axis_1553_decoder.sv
// Directed bench for axis_1553_decoder at 20 MHz (20 samples per bit).
// Expected words are queued as stimulus is sent and checked at each handshake.
`timescale 1ns/1ps
module tb_axis_1553_decoder;

  localparam logic [1:0] HI = 2'b10;
  localparam logic [1:0] LO = 2'b01;

  typedef struct packed {
    logic [15:0] d;
    logic [7:0]  u;
  } exp_t;

  logic        tb_data_clk = 1'b0;
  logic        arst;
  logic [1:0]  diff;
  logic [15:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic [7:0]  m_axis_tuser;
  logic        m_axis_tready;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  always #25 tb_data_clk = ~tb_data_clk;

  axis_1553_decoder #(.clock_speed(20000000)) dut (
    .aclk          (tb_data_clk),
    .arst          (arst),
    .diff          (diff),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tready (m_axis_tready)
  );

  // any valid word must match the queue head; held words are compared each cycle
  always @(negedge tb_data_clk) begin
    if (!arst && m_axis_tvalid) begin
      checks++;
      assert (q.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_word: got tdata=%h tuser=%h want none",
               m_axis_tdata, m_axis_tuser);
      end
      if (q.size() != 0) begin
        checks++;
        assert (m_axis_tdata === q[0].d) else begin
          errors++;
          $error("FAIL tdata: got %h want %h", m_axis_tdata, q[0].d);
        end
        checks++;
        assert (m_axis_tuser === q[0].u) else begin
          errors++;
          $error("FAIL tuser(%h): got %h want %h",
                 q[0].d, m_axis_tuser, q[0].u);
        end
        if (m_axis_tready) void'(q.pop_front());
      end
    end
  end

  task automatic hl(input logic [1:0] v, input int n);
    diff = v;
    repeat (n) @(posedge tb_data_clk);
    #1;
  endtask

  task automatic sync(input bit cmd, input int first_len);
    hl(cmd ? HI : LO, first_len);
    hl(cmd ? LO : HI, 30);
  endtask

  task automatic bits(input logic [15:0] d, input bit par,
                      input int bad, input int rstb);
    logic [16:0] w;
    logic b;
    w = {d, par};
    for (int i = 0; i < 17; i++) begin
      b = w[16-i];
      if (i == bad) begin
        hl(HI, 20);
      end else begin
        if (i == rstb) arst = 1'b1;
        hl(b ? HI : LO, 10);
        if (i == rstb) begin
          checks++;
          assert (m_axis_tvalid === 1'b0) else begin
            errors++;
            $error("FAIL rst_mid_tvalid: got %b want 0", m_axis_tvalid);
          end
          checks++;
          assert (m_axis_tdata === 16'h0000) else begin
            errors++;
            $error("FAIL rst_mid_tdata: got %h want 0000", m_axis_tdata);
          end
          arst = 1'b0;
        end
        hl(b ? LO : HI, 10);
      end
    end
  endtask

  task automatic send(input bit cmd, input logic [15:0] d, input bit par);
    sync(cmd, 30);
    bits(d, par, -1, -1);
  endtask

  task automatic expect_word(input logic [15:0] d, input logic [7:0] u);
    exp_t e;
    e.d = d;
    e.u = u;
    q.push_back(e);
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (q.size() != 0 && n < 400) begin
      @(posedge tb_data_clk);
      n++;
    end
    #1;
    checks++;
    assert (q.size() == 0) else begin
      errors++;
      $error("FAIL %s: got %0d pending words want 0", tag, q.size());
    end
  endtask

  initial begin
    arst          = 1'b1;
    diff          = 2'b00;
    m_axis_tready = 1'b1;
    repeat (4) @(posedge tb_data_clk);
    #1;
    checks++;
    assert (m_axis_tvalid === 1'b0) else begin
      errors++;
      $error("FAIL reset_tvalid: got %b want 0", m_axis_tvalid);
    end
    checks++;
    assert (m_axis_tdata === 16'h0000) else begin
      errors++;
      $error("FAIL reset_tdata: got %h want 0000", m_axis_tdata);
    end
    checks++;
    assert (m_axis_tuser === 8'h00) else begin
      errors++;
      $error("FAIL reset_tuser: got %h want 00", m_axis_tuser);
    end
    arst = 1'b0;
    hl(2'b00, 10);

    // command word
    expect_word(16'h1234, 8'h01);
    send(1'b1, 16'h1234, 1'b0);
    hl(2'b00, 10);
    drain("cmd_1234");

    // data words, good and bad parity
    expect_word(16'hFFFF, 8'h00);
    send(1'b0, 16'hFFFF, 1'b1);
    hl(2'b00, 10);
    expect_word(16'hFFFF, 8'h02);
    send(1'b0, 16'hFFFF, 1'b0);
    hl(2'b00, 10);
    drain("data_ffff");

    // Manchester violation on bit 5, then a clean word
    sync(1'b1, 30);
    bits(16'h1234, 1'b0, 5, -1);
    hl(2'b00, 10);
    expect_word(16'h00A5, 8'h00);
    send(1'b0, 16'h00A5, 1'b1);
    hl(2'b00, 10);
    drain("after_violation");

    // stall across three words
    m_axis_tready = 1'b0;
    expect_word(16'h0001, 8'h01);
    send(1'b1, 16'h0001, 1'b0);
    hl(2'b00, 10);
    send(1'b1, 16'h0002, 1'b0);
    hl(2'b00, 10);
    send(1'b1, 16'h0003, 1'b1);
    hl(2'b00, 10);
    m_axis_tready = 1'b1;
    drain("stalled_0001");
    expect_word(16'h0004, 8'h05);
    send(1'b1, 16'h0004, 1'b0);
    hl(2'b00, 10);
    expect_word(16'h0005, 8'h01);
    send(1'b1, 16'h0005, 1'b1);
    hl(2'b00, 10);
    drain("overflow_flag");

    // back-to-back: parity 1 ends LO, next command sync starts HI
    expect_word(16'h0000, 8'h01);
    expect_word(16'h1234, 8'h01);
    send(1'b1, 16'h0000, 1'b1);
    send(1'b1, 16'h1234, 1'b0);
    hl(2'b00, 10);
    drain("back_to_back");

    // short sync, then invalid level inside a sync
    sync(1'b1, 20);
    bits(16'h1234, 1'b0, -1, -1);
    hl(2'b00, 10);
    hl(HI, 15);
    hl(2'b11, 2);
    hl(HI, 13);
    hl(LO, 30);
    bits(16'h1234, 1'b0, -1, -1);
    hl(2'b00, 10);
    expect_word(16'h5A5A, 8'h00);
    send(1'b0, 16'h5A5A, 1'b1);
    hl(2'b00, 10);
    drain("bad_syncs");

    // reset during bit 8, then a clean word
    sync(1'b1, 30);
    bits(16'h1234, 1'b0, -1, 8);
    hl(2'b00, 10);
    expect_word(16'hBEEF, 8'h01);
    send(1'b1, 16'hBEEF, 1'b0);
    hl(2'b00, 10);
    drain("after_reset");

    hl(2'b00, 20);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
